hall_emulator: RTL and testbench

Synthesizable motor-side stand-in for bench bring-up of the BLDC drive chain without a motor attached. It generates a commanded 120° hall sequence at a programmable step rate and direction, with injectable hall faults. It also watches the phase gate outputs returned by the driver and flags shoot-through and commutation errors. It sits between the FPGA's phase outputs and the hall inputs of one motor channel, selected in place of the real hall pins by a build-time mux.

---
 rtl/hall_emulator_pkg.sv | 49 ++++
 rtl/hall_emulator_if.sv | 32 +++
 rtl/hall_emulator_step_gen.sv | 66 ++++++
 rtl/hall_emulator.sv | 90 +++++++++
 tb/tb_hall_emulator.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/hall_emulator_pkg.sv
// Shared hall sequencing tables and fault-mode encodings for the hall emulator
// and the BLDC driver bench.
package hall_pkg;

  typedef enum logic [1:0] {
    FM_NORMAL = 2'b00,
    FM_FORCE0 = 2'b01,
    FM_FORCE1 = 2'b10,
    FM_SKIP   = 2'b11
  } fault_mode_t;

  localparam logic [2:0] HALL_SEQ [0:5] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b100, 3'b101};
  localparam logic [1:0] FLOAT_PHASE [0:5] = '{2'd1, 2'd0, 2'd2, 2'd1, 2'd0, 2'd2};

  // Case form of HALL_SEQ so an out-of-range index can never escape the table.
  function automatic logic [2:0] hall_of(input logic [2:0] k);
    logic [2:0] h;
    case (k)
      3'd0:    h = 3'b001;
      3'd1:    h = 3'b011;
      3'd2:    h = 3'b010;
      3'd3:    h = 3'b110;
      3'd4:    h = 3'b100;
      3'd5:    h = 3'b101;
      default: h = 3'b001;
    endcase
    return h;
  endfunction

  // One-hot mask of the floating phase for index k (FLOAT_PHASE as a mask).
  function automatic logic [2:0] float_mask(input logic [2:0] k);
    logic [2:0] m;
    case (k)
      3'd0, 3'd3: m = 3'b010;
      3'd1, 3'd4: m = 3'b001;
      3'd2, 3'd5: m = 3'b100;
      default:    m = 3'b000;
    endcase
    return m;
  endfunction

  function automatic logic [2:0] idx_add(input logic [2:0] k, input logic [2:0] d);
    logic [3:0] s;
    s = {1'b0, k} + {1'b0, d};
    if (s >= 4'd6) s = s - 4'd6;
    return s[2:0];
  endfunction

endpackage

// File: rtl/hall_emulator_if.sv
// Control, observation and hall-output signals between the bench/host side
// and the hall emulator.
interface hall_emulator_if
  import hall_pkg::*;
#(
  parameter int PERIOD_WIDTH = 16,
  parameter int POS_WIDTH    = 16,
  parameter int ERR_WIDTH    = 8
);
  logic                        en;
  logic                        dir;
  logic [PERIOD_WIDTH-1:0]     step_period;
  fault_mode_t                 fault_mode;
  logic                        clr_err;
  logic [2:0]                  phaseH;
  logic [2:0]                  phaseL;
  logic [2:0]                  hall;
  logic                        step_strobe;
  logic signed [POS_WIDTH-1:0] position;
  logic                        shoot_through;
  logic [ERR_WIDTH-1:0]        comm_err_cnt;

  modport master (
    output en, dir, step_period, fault_mode, clr_err, phaseH, phaseL,
    input  hall, step_strobe, position, shoot_through, comm_err_cnt
  );

  modport slave (
    input  en, dir, step_period, fault_mode, clr_err, phaseH, phaseL,
    output hall, step_strobe, position, shoot_through, comm_err_cnt
  );
endinterface

// File: rtl/hall_emulator_step_gen.sv
// Step timer, hall index and signed position. idx_next is exposed so the top
// can register hall in the same edge that idx advances.
module hall_step_gen
  import hall_pkg::*;
#(
  parameter int PERIOD_WIDTH = 16,
  parameter int POS_WIDTH    = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        dir,
  input  logic [PERIOD_WIDTH-1:0]     step_period,
  input  fault_mode_t                 fault_mode,
  output logic [2:0]                  idx,
  output logic [2:0]                  idx_next,
  output logic                        step_strobe,
  output logic signed [POS_WIDTH-1:0] position
);

  logic [PERIOD_WIDTH-1:0] cnt, cnt_next;
  logic                    step, step_en;
  logic [2:0]              delta;

  always_comb begin
    step     = 1'b0;
    cnt_next = cnt;
    idx_next = idx;
    delta    = 3'd1;
    step_en  = en && (step_period != '0) &&
               (fault_mode == FM_NORMAL || fault_mode == FM_SKIP);
    // >= compare so a period shortened below the running count steps at once.
    if (step_en) begin
      if (cnt >= step_period - PERIOD_WIDTH'(1)) begin
        step     = 1'b1;
        cnt_next = '0;
      end else begin
        cnt_next = cnt + PERIOD_WIDTH'(1);
      end
    end else if (!en || step_period == '0) begin
      cnt_next = '0;
    end
    case ({dir, fault_mode == FM_SKIP})
      2'b00:   delta = 3'd1;
      2'b01:   delta = 3'd2;
      2'b10:   delta = 3'd5;
      default: delta = 3'd4;
    endcase
    if (step) idx_next = idx_add(idx, delta);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      idx         <= 3'd0;
      step_strobe <= 1'b0;
      position    <= '0;
    end else begin
      cnt         <= cnt_next;
      idx         <= idx_next;
      step_strobe <= step;
      if (step) position <= dir ? position - POS_WIDTH'(1) : position + POS_WIDTH'(1);
    end
  end

endmodule

// File: rtl/hall_emulator.sv
// Motor-side hall emulator: stepped hall output with fault forcing, plus
// shoot-through and commutation checks on the returned gate drives.
module hall_emulator
  import hall_pkg::*;
#(
  parameter int PERIOD_WIDTH = 16,
  parameter int POS_WIDTH    = 16,
  parameter int ERR_WIDTH    = 8,
  parameter int SETTLE       = 8
) (
  input logic            clk,
  input logic            rst,
  hall_emulator_if.slave bus
);

  localparam int SW = $clog2(SETTLE + 1);

  logic [2:0]  idx, idx_next;
  logic [2:0]  hall_d, hall_q;
  logic [SW-1:0] settle;
  logic [2:0]  ph_h_s1, ph_h_s2, ph_l_s1, ph_l_s2;
  logic        mismatch, shoot_now;
  logic        shoot_q;
  logic [ERR_WIDTH-1:0] err_cnt;

  hall_step_gen #(
    .PERIOD_WIDTH (PERIOD_WIDTH),
    .POS_WIDTH    (POS_WIDTH)
  ) u_step_gen (
    .clk         (clk),
    .rst         (rst),
    .en          (bus.en),
    .dir         (bus.dir),
    .step_period (bus.step_period),
    .fault_mode  (bus.fault_mode),
    .idx         (idx),
    .idx_next    (idx_next),
    .step_strobe (bus.step_strobe),
    .position    (bus.position)
  );

  always_comb begin
    hall_d = hall_of(idx_next);
    case (bus.fault_mode)
      FM_FORCE0: hall_d = 3'b000;
      FM_FORCE1: hall_d = 3'b111;
      default:   hall_d = hall_of(idx_next);
    endcase
  end

  always_comb begin
    shoot_now = |(ph_h_s2 & ph_l_s2);
    mismatch  = (settle == '0) && (bus.fault_mode == FM_NORMAL) &&
                (|((ph_h_s2 | ph_l_s2) & float_mask(idx)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hall_q  <= 3'b001;
      settle  <= SW'(SETTLE);
      ph_h_s1 <= '0;
      ph_h_s2 <= '0;
      ph_l_s1 <= '0;
      ph_l_s2 <= '0;
      shoot_q <= 1'b0;
      err_cnt <= '0;
    end else begin
      hall_q  <= hall_d;
      // Any visible hall edge, fault entry/exit included, restarts the blanking window.
      if (hall_d != hall_q)  settle <= SW'(SETTLE);
      else if (settle != '0) settle <= settle - SW'(1);
      ph_h_s1 <= bus.phaseH;
      ph_h_s2 <= ph_h_s1;
      ph_l_s1 <= bus.phaseL;
      ph_l_s2 <= ph_l_s1;
      if (bus.clr_err) begin
        shoot_q <= 1'b0;
        err_cnt <= '0;
      end else begin
        if (shoot_now) shoot_q <= 1'b1;
        if (mismatch && err_cnt != '1) err_cnt <= err_cnt + ERR_WIDTH'(1);
      end
    end
  end

  assign bus.hall          = hall_q;
  assign bus.shoot_through = shoot_q;
  assign bus.comm_err_cnt  = err_cnt;

endmodule

// File: tb/tb_hall_emulator.sv
// Directed bench for hall_emulator: stepping, reverse, fault forcing,
// commutation/shoot-through checks and period change.
module tb_hall_emulator;
  import hall_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  localparam logic [2:0] EXP_SEQ [0:5] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b100, 3'b101};

  hall_emulator_if #(.PERIOD_WIDTH(16), .POS_WIDTH(16), .ERR_WIDTH(8)) bus ();

  hall_emulator #(
    .PERIOD_WIDTH (16),
    .POS_WIDTH    (16),
    .ERR_WIDTH    (8),
    .SETTLE       (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    bus.en = 1'b0; bus.dir = 1'b0; bus.step_period = '0; bus.fault_mode = FM_NORMAL;
    bus.clr_err = 1'b0; bus.phaseH = 3'b000; bus.phaseL = 3'b000;
    tick(2);
    chk("rst_hall", {29'd0, bus.hall}, 32'h1);
    chk("rst_pos", {16'd0, bus.position}, 32'h0);
    chk("rst_strobe", {31'd0, bus.step_strobe}, 32'h0);
    chk("rst_shoot", {31'd0, bus.shoot_through}, 32'h0);
    chk("rst_err", {24'd0, bus.comm_err_cnt}, 32'h0);

    // forward, period 4
    rst = 1'b0; bus.en = 1'b1; bus.dir = 1'b0; bus.step_period = 16'd4;
    for (int i = 1; i <= 6; i++) begin
      tick(3);
      chk("fwd_hold_strobe", {31'd0, bus.step_strobe}, 32'h0);
      chk("fwd_hold_hall", {29'd0, bus.hall}, {29'd0, EXP_SEQ[(i-1)%6]});
      tick(1);
      chk("fwd_strobe", {31'd0, bus.step_strobe}, 32'h1);
      chk("fwd_hall", {29'd0, bus.hall}, {29'd0, EXP_SEQ[i%6]});
    end
    chk("fwd_pos6", {16'd0, bus.position}, 32'h6);

    // asynchronous reset mid-run
    rst = 1'b1;
    #1;
    chk("async_rst_hall", {29'd0, bus.hall}, 32'h1);
    chk("async_rst_pos", {16'd0, bus.position}, 32'h0);
    tick(1);
    rst = 1'b0; bus.dir = 1'b1; bus.step_period = 16'd2;
    tick(2);
    chk("rev_hall1", {29'd0, bus.hall}, 32'h5);
    chk("rev_pos1", {16'd0, bus.position}, 32'hFFFF);
    tick(2);
    chk("rev_hall2", {29'd0, bus.hall}, 32'h4);
    chk("rev_pos2", {16'd0, bus.position}, 32'hFFFE);

    // force hall 111 for 50 cycles
    bus.fault_mode = FM_FORCE1;
    tick(1);
    chk("f1_entry_hall", {29'd0, bus.hall}, 32'h7);
    tick(49);
    chk("f1_hall", {29'd0, bus.hall}, 32'h7);
    chk("f1_pos", {16'd0, bus.position}, 32'hFFFE);
    chk("f1_strobe", {31'd0, bus.step_strobe}, 32'h0);
    bus.fault_mode = FM_NORMAL;
    tick(1);
    chk("f1_exit_hall", {29'd0, bus.hall}, 32'h4);
    chk("f1_exit_strobe", {31'd0, bus.step_strobe}, 32'h0);
    tick(1);
    chk("post_fault_hall", {29'd0, bus.hall}, 32'h6);
    chk("post_fault_strobe", {31'd0, bus.step_strobe}, 32'h1);
    chk("post_fault_pos", {16'd0, bus.position}, 32'hFFFD);
    bus.en = 1'b0;

    // commutation check at k=0
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(10);
    bus.phaseH = 3'b010;
    tick(2);
    chk("comm_lag", {24'd0, bus.comm_err_cnt}, 32'h0);
    tick(1);
    chk("comm_first", {24'd0, bus.comm_err_cnt}, 32'h1);
    tick(2);
    bus.phaseH = 3'b000;
    tick(3);
    chk("comm_five", {24'd0, bus.comm_err_cnt}, 32'h5);
    bus.clr_err = 1'b1;
    tick(1);
    chk("comm_clr", {24'd0, bus.comm_err_cnt}, 32'h0);
    bus.clr_err = 1'b0;

    // clear wins over a persisting error, which re-registers next cycle
    bus.phaseH = 3'b010;
    tick(4);
    chk("comm_pre_clr", {24'd0, bus.comm_err_cnt}, 32'h2);
    bus.clr_err = 1'b1;
    tick(1);
    chk("comm_clr_wins", {24'd0, bus.comm_err_cnt}, 32'h0);
    bus.clr_err = 1'b0;
    tick(1);
    chk("comm_reregister", {24'd0, bus.comm_err_cnt}, 32'h1);
    bus.phaseH = 3'b000;
    tick(4);
    chk("comm_tail", {24'd0, bus.comm_err_cnt}, 32'h3);

    // shoot-through on phase 2, one-cycle pulse
    bus.phaseH = 3'b100; bus.phaseL = 3'b100;
    tick(1);
    bus.phaseH = 3'b000; bus.phaseL = 3'b000;
    tick(1);
    chk("st_lag", {31'd0, bus.shoot_through}, 32'h0);
    tick(1);
    chk("st_set", {31'd0, bus.shoot_through}, 32'h1);
    tick(10);
    chk("st_sticky", {31'd0, bus.shoot_through}, 32'h1);
    bus.clr_err = 1'b1;
    tick(1);
    chk("st_clr", {31'd0, bus.shoot_through}, 32'h0);
    bus.clr_err = 1'b0;
    tick(1);
    chk("st_stays_clr", {31'd0, bus.shoot_through}, 32'h0);

    // period lowered below the running count
    bus.en = 1'b1; bus.dir = 1'b0; bus.step_period = 16'd100;
    tick(60);
    chk("long_no_strobe", {31'd0, bus.step_strobe}, 32'h0);
    chk("long_hall", {29'd0, bus.hall}, 32'h1);
    bus.step_period = 16'd10;
    tick(1);
    chk("shorten_strobe", {31'd0, bus.step_strobe}, 32'h1);
    chk("shorten_hall", {29'd0, bus.hall}, 32'h3);
    tick(9);
    chk("p10_gap", {31'd0, bus.step_strobe}, 32'h0);
    tick(1);
    chk("p10_strobe", {31'd0, bus.step_strobe}, 32'h1);
    chk("p10_hall", {29'd0, bus.hall}, 32'h2);
    chk("p10_pos", {16'd0, bus.position}, 32'h2);

    // period 1 then skip mode
    bus.step_period = 16'd1;
    tick(1);
    chk("p1_strobe_a", {31'd0, bus.step_strobe}, 32'h1);
    chk("p1_hall_a", {29'd0, bus.hall}, 32'h6);
    tick(1);
    chk("p1_strobe_b", {31'd0, bus.step_strobe}, 32'h1);
    chk("p1_hall_b", {29'd0, bus.hall}, 32'h4);
    chk("p1_pos", {16'd0, bus.position}, 32'h4);
    bus.fault_mode = FM_SKIP;
    tick(1);
    chk("skip_hall_a", {29'd0, bus.hall}, 32'h1);
    chk("skip_pos_a", {16'd0, bus.position}, 32'h5);
    tick(1);
    chk("skip_hall_b", {29'd0, bus.hall}, 32'h2);
    chk("skip_pos_b", {16'd0, bus.position}, 32'h6);
    bus.en = 1'b0;
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
